// File: rtl/zeroheti_pkg.sv
// Shared types and constants for the zeroHETI system-bus arbitration logic.
package zeroheti_pkg;

  // Identifies which manager port owns a transaction on the system bus.
  typedef enum logic {
    SrcCore = 1'b0,
    SrcSba  = 1'b1
  } arb_src_e;

  // Number of accepted-but-unanswered transactions the SBA arbiter tracks by default.
  localparam int unsigned SbaMaxOutstanding = 2;

endpackage

// File: rtl/zeroheti_src_fifo.sv
// Small FIFO of source indices. It remembers which manager issued each
// outstanding transaction so responses can be routed back in order.
module zeroheti_src_fifo
  import zeroheti_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  logic     pop_i,
  input  arb_src_e data_in_i,
  output arb_src_e head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  arb_src_e        r_mem [Depth];
  logic [PtrW-1:0] r_wrPtr;
  logic [PtrW-1:0] r_rdPtr;
  logic [CntW-1:0] r_count;

  logic w_doPush;
  logic w_doPop;

  // Pointers wrap explicitly so that a depth of one also works.
  function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] ptr);
    if (ptr == PtrW'(Depth - 1)) begin
      return '0;
    end
    return ptr + 1'b1;
  endfunction

  assign full_o   = (r_count == CntW'(Depth));
  assign empty_o  = (r_count == '0);
  assign head_o   = r_mem[r_rdPtr];
  assign w_doPush = push_i & ~full_o;
  assign w_doPop  = pop_i & ~empty_o;

  // Storage and write pointer: a push writes the slot under the write pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        r_mem[i] <= SrcCore;
      end
      r_wrPtr <= '0;
    end else if (w_doPush) begin
      r_mem[r_wrPtr] <= data_in_i;
      r_wrPtr        <= nextPtr(r_wrPtr);
    end
  end

  // Read pointer advances on every accepted pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rdPtr <= '0;
    end else if (w_doPop) begin
      r_rdPtr <= nextPtr(r_rdPtr);
    end
  end

  // Occupancy: a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else begin
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/zeroheti_sba_arbiter.sv
// 2:1 OBI arbiter that merges the core LSU port and the debug SBA port onto
// the single system-bus manager port. Requests are arbitrated round-robin;
// responses are routed back in order using a FIFO of source indices.
module zeroheti_sba_arbiter
  import zeroheti_pkg::*;
#(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = SbaMaxOutstanding
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   core_req_i,
  output logic                   core_gnt_o,
  input  logic [AddrWidth-1:0]   core_addr_i,
  input  logic                   core_we_i,
  input  logic [DataWidth/8-1:0] core_be_i,
  input  logic [DataWidth-1:0]   core_wdata_i,
  output logic                   core_rvalid_o,
  output logic [DataWidth-1:0]   core_rdata_o,
  output logic                   core_err_o,
  input  logic                   sba_req_i,
  output logic                   sba_gnt_o,
  input  logic [AddrWidth-1:0]   sba_addr_i,
  input  logic                   sba_we_i,
  input  logic [DataWidth/8-1:0] sba_be_i,
  input  logic [DataWidth-1:0]   sba_wdata_i,
  output logic                   sba_rvalid_o,
  output logic [DataWidth-1:0]   sba_rdata_o,
  output logic                   sba_err_o,
  output logic                   sys_req_o,
  input  logic                   sys_gnt_i,
  output logic [AddrWidth-1:0]   sys_addr_o,
  output logic                   sys_we_o,
  output logic [DataWidth/8-1:0] sys_be_o,
  output logic [DataWidth-1:0]   sys_wdata_o,
  input  logic                   sys_rvalid_i,
  input  logic [DataWidth-1:0]   sys_rdata_i,
  input  logic                   sys_err_i,
  output logic                   unexp_rsp_o
);

  arb_src_e r_rrPtr;
  logic     r_unexp;

  arb_src_e w_sel;
  arb_src_e w_head;
  logic     w_full;
  logic     w_empty;
  logic     w_grant;
  logic     w_handshake;
  logic     w_pop;

  // Pick the sole requester, or the round-robin favourite when both request.
  always_comb begin
    w_sel = SrcCore;
    if (core_req_i && sba_req_i) begin
      w_sel = r_rrPtr;
    end else if (sba_req_i) begin
      w_sel = SrcSba;
    end
  end

  // Forward the selected port's A-channel fields to the system bus.
  always_comb begin
    sys_addr_o  = core_addr_i;
    sys_we_o    = core_we_i;
    sys_be_o    = core_be_i;
    sys_wdata_o = core_wdata_i;
    if (w_sel == SrcSba) begin
      sys_addr_o  = sba_addr_i;
      sys_we_o    = sba_we_i;
      sys_be_o    = sba_be_i;
      sys_wdata_o = sba_wdata_i;
    end
  end

  // No request leaves and no grant returns while the tracker is full, even if
  // a response frees a slot in the same cycle.
  assign sys_req_o   = (core_req_i | sba_req_i) & ~w_full;
  assign w_grant     = sys_gnt_i & ~w_full;
  assign w_handshake = sys_req_o & sys_gnt_i;
  assign core_gnt_o  = w_grant & core_req_i & (w_sel == SrcCore);
  assign sba_gnt_o   = w_grant & sba_req_i & (w_sel == SrcSba);

  // A response belongs to the oldest outstanding transaction.
  assign w_pop         = sys_rvalid_i & ~w_empty;
  assign core_rvalid_o = w_pop & (w_head == SrcCore);
  assign sba_rvalid_o  = w_pop & (w_head == SrcSba);
  assign core_rdata_o  = core_rvalid_o ? sys_rdata_i : '0;
  assign sba_rdata_o   = sba_rvalid_o ? sys_rdata_i : '0;
  assign core_err_o    = core_rvalid_o & sys_err_i;
  assign sba_err_o     = sba_rvalid_o & sys_err_i;
  assign unexp_rsp_o   = r_unexp;

  zeroheti_src_fifo #(
    .Depth(MaxOutstanding)
  ) u_srcFifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_i   (w_handshake),
    .pop_i    (w_pop),
    .data_in_i(w_sel),
    .head_o   (w_head),
    .full_o   (w_full),
    .empty_o  (w_empty)
  );

  // After each accepted request, favour the port that was not served.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rrPtr <= SrcCore;
    end else if (w_handshake) begin
      r_rrPtr <= (w_sel == SrcCore) ? SrcSba : SrcCore;
    end
  end

  // Remember any response that arrived with nothing outstanding.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_unexp <= 1'b0;
    end else if (sys_rvalid_i && w_empty) begin
      r_unexp <= 1'b1;
    end
  end

endmodule
